// File: rtl/pc_sequencer.sv
// Timing/control sequencer for a basic accumulator machine: sequence counter,
// run flag and PC strobes. Define INTERRUPT_EN to compile in interrupt support.
module pc_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] IR,
  input  logic        DR_ZERO,
  input  logic        AC_SIGN,
  input  logic        AC_ZERO,
  input  logic        E,
  input  logic        FGI,
  input  logic        FGO,
  output logic [3:0]  SC,
  output logic        PC_CLR,
  output logic        PC_INC,
  output logic        PC_LD,
  output logic        RUN,
  output logic        IEN,
  output logic        R
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic       ien_q, r_q;
  logic       pc_clr, pc_inc, pc_ld;
  logic       end_step, halt, skip;
  logic [2:0] dec;
  logic       ind;

`ifdef INTERRUPT_EN
  logic ien_d, r_d;
`endif

  assign dec  = IR[14:12];
  assign ind  = IR[15];
  assign skip = (IR[4] & ~AC_SIGN) | (IR[3] & AC_SIGN) | (IR[2] & AC_ZERO) | (IR[1] & ~E);

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    end_step = 1'b0;
    halt     = 1'b0;
`ifdef INTERRUPT_EN
    ien_d    = ien_q;
    r_d      = r_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        sc_d = '0;
        if (START) state_d = ST_RUN;
      end
      ST_RUN: begin
        // R only selects fetch vs interrupt cycle in T0-T2; execute steps ignore it
        if (sc_q <= 4'd2) begin
          if (r_q) begin
            if (sc_q == 4'd1) pc_clr = 1'b1;
            if (sc_q == 4'd2) begin
              pc_inc   = 1'b1;
              end_step = 1'b1;
`ifdef INTERRUPT_EN
              ien_d    = 1'b0;
              r_d      = 1'b0;
`endif
            end
          end else if (sc_q == 4'd1) begin
            pc_inc = 1'b1;
          end
        end else begin
          unique case (dec)
            3'd0, 3'd1, 3'd2: end_step = (sc_q == 4'd5);
            3'd3:             end_step = (sc_q == 4'd4);
            3'd4: begin
              end_step = (sc_q == 4'd4);
              pc_ld    = (sc_q == 4'd4);
            end
            3'd5: begin
              end_step = (sc_q == 4'd5);
              pc_ld    = (sc_q == 4'd5);
            end
            3'd6: begin
              end_step = (sc_q == 4'd6);
              pc_inc   = (sc_q == 4'd6) & DR_ZERO;
            end
            3'd7: begin
              end_step = (sc_q == 4'd3);
              if (sc_q == 4'd3) begin
                if (!ind) begin
                  pc_inc = skip;
                  halt   = IR[0];
                end
`ifdef INTERRUPT_EN
                else begin
                  if (IR[7]) ien_d = 1'b1;
                  if (IR[6]) ien_d = 1'b0;
                end
`endif
              end
            end
            default: end_step = 1'b1;
          endcase
`ifdef INTERRUPT_EN
          if (ien_q && (FGI || FGO)) r_d = 1'b1;
`endif
        end
        // An IR change mid-instruction must never let SC run past T15
        if (sc_q == 4'hF) end_step = 1'b1;
        sc_d = end_step ? '0 : sc_q + 4'd1;
        if (halt) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
    end
  end

`ifdef INTERRUPT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ien_q <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      ien_q <= ien_d;
      r_q   <= r_d;
    end
  end
`else
  assign ien_q = 1'b0;
  assign r_q   = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{IR[11:8], IR[7:5], FGI, FGO, ien_q};

  // Reset forces the visible state immediately, not just after the edge
  assign SC     = RST ? '0 : sc_q;
  assign RUN    = ~RST & (state_q == ST_RUN);
  assign PC_CLR = RST | pc_clr;
  assign PC_INC = ~RST & pc_inc;
  assign PC_LD  = ~RST & pc_ld;
  assign IEN    = ~RST & ien_q;
  assign R      = ~RST & r_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; expectations come from per-instruction
// step tables. Covers both builds (INTERRUPT_EN defined or not).
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, DR_ZERO, AC_SIGN, AC_ZERO, E, FGI, FGO;
  logic [15:0] IR;
  logic [3:0]  SC;
  logic        PC_CLR, PC_INC, PC_LD, RUN, IEN, R;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        model_ien = 1'b0;

`ifdef INTERRUPT_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  pc_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .IR(IR), .DR_ZERO(DR_ZERO),
    .AC_SIGN(AC_SIGN), .AC_ZERO(AC_ZERO), .E(E), .FGI(FGI), .FGO(FGO),
    .SC(SC), .PC_CLR(PC_CLR), .PC_INC(PC_INC), .PC_LD(PC_LD),
    .RUN(RUN), .IEN(IEN), .R(R)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Last step of each instruction class
  function automatic int last_t(input logic [15:0] ir);
    case (ir[14:12])
      3'd0, 3'd1, 3'd2, 3'd5: return 5;
      3'd3, 3'd4:             return 4;
      3'd6:                   return 6;
      default:                return 3;
    endcase
  endfunction

  function automatic logic exp_inc(input int t, input logic [15:0] ir,
                                   input logic dz, input logic as, input logic az, input logic e);
    if (t == 1) return 1'b1;
    if (ir[14:12] == 3'd7 && !ir[15] && t == 3)
      return (ir[4] && !as) || (ir[3] && as) || (ir[2] && az) || (ir[1] && !e);
    if (ir[14:12] == 3'd6 && t == 6) return dz;
    return 1'b0;
  endfunction

  function automatic logic exp_ld(input int t, input logic [15:0] ir);
    return (ir[14:12] == 3'd4 && t == 4) || (ir[14:12] == 3'd5 && t == 5);
  endfunction

  task automatic start_pulse();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++; if (PC_CLR !== 1'b1) begin n_err++; $display("FAIL rst_pc_clr: got %b want 1", PC_CLR); end
      n_cmp++; if (SC !== 4'd0) begin n_err++; $display("FAIL rst_sc: got %0d want 0", SC); end
      n_cmp++; if (RUN !== 1'b0) begin n_err++; $display("FAIL rst_run: got %b want 0", RUN); end
      n_cmp++; if (PC_INC !== 1'b0 || PC_LD !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got inc=%b ld=%b want 0 0", PC_INC, PC_LD); end
      n_cmp++; if (IEN !== 1'b0 || R !== 1'b0) begin n_err++; $display("FAIL rst_ien_r: got ien=%b r=%b want 0 0", IEN, R); end
      tick();
    end
    RST = 1'b0;
    START = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++; if (RUN !== 1'b0 || SC !== 4'd0) begin n_err++; $display("FAIL idle_after_rst: got run=%b sc=%0d want 0 0", RUN, SC); end
      n_cmp++; if (PC_CLR !== 1'b0 || PC_INC !== 1'b0 || PC_LD !== 1'b0) begin n_err++; $display("FAIL idle_strobes: got clr=%b inc=%b ld=%b want 000", PC_CLR, PC_INC, PC_LD); end
      tick();
    end
  endtask

  task automatic test_fetch();
    IR = 16'h3123;
    start_pulse();
    for (int t = 0; t <= 4; t++) begin
      @(negedge CLK);
      n_cmp++; if (SC !== 4'(t)) begin n_err++; $display("FAIL fetch_sc: got %0d want %0d", SC, t); end
      n_cmp++; if (RUN !== 1'b1) begin n_err++; $display("FAIL fetch_run T%0d: got %b want 1", t, RUN); end
      n_cmp++; if (PC_INC !== (t == 1)) begin n_err++; $display("FAIL fetch_inc T%0d: got %b want %b", t, PC_INC, t == 1); end
      tick();
    end
  endtask

  task automatic test_memref();
    logic [15:0] irs[4] = '{16'h4123, 16'h5123, 16'h6123, 16'h6123};
    logic        dzs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      IR = irs[k];
      DR_ZERO = dzs[k];
      for (int t = 0; t <= last_t(irs[k]); t++) begin
        @(negedge CLK);
        n_cmp++; if (SC !== 4'(t)) begin n_err++; $display("FAIL memref_sc ir=%h: got %0d want %0d", IR, SC, t); end
        n_cmp++; if (PC_INC !== exp_inc(t, IR, DR_ZERO, AC_SIGN, AC_ZERO, E)) begin n_err++; $display("FAIL memref_inc ir=%h T%0d: got %b want %b", IR, t, PC_INC, exp_inc(t, IR, DR_ZERO, AC_SIGN, AC_ZERO, E)); end
        n_cmp++; if (PC_LD !== exp_ld(t, IR)) begin n_err++; $display("FAIL memref_ld ir=%h T%0d: got %b want %b", IR, t, PC_LD, exp_ld(t, IR)); end
        tick();
      end
    end
  endtask

  task automatic test_regref_halt();
    logic [15:0] irs[4] = '{16'h7004, 16'h7004, 16'h7010, 16'h7008};
    logic        azs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        ass[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      IR = irs[k];
      AC_ZERO = azs[k];
      AC_SIGN = ass[k];
      for (int t = 0; t <= 3; t++) begin
        @(negedge CLK);
        n_cmp++; if (SC !== 4'(t)) begin n_err++; $display("FAIL regref_sc ir=%h: got %0d want %0d", IR, SC, t); end
        n_cmp++; if (PC_INC !== exp_inc(t, IR, DR_ZERO, AC_SIGN, AC_ZERO, E)) begin n_err++; $display("FAIL regref_inc ir=%h T%0d: got %b want %b", IR, t, PC_INC, exp_inc(t, IR, DR_ZERO, AC_SIGN, AC_ZERO, E)); end
        tick();
      end
    end
    IR = 16'h7001;
    for (int t = 0; t <= 3; t++) begin
      if (t == 3) START = 1'b1;
      @(negedge CLK);
      n_cmp++; if (SC !== 4'(t) || RUN !== 1'b1) begin n_err++; $display("FAIL hlt_seq T%0d: got sc=%0d run=%b want %0d 1", t, SC, RUN, t); end
      tick();
    end
    START = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++; if (RUN !== 1'b0 || SC !== 4'd0) begin n_err++; $display("FAIL hlt_stop: got run=%b sc=%0d want 0 0", RUN, SC); end
      n_cmp++; if (PC_CLR !== 1'b0 || PC_INC !== 1'b0 || PC_LD !== 1'b0) begin n_err++; $display("FAIL hlt_strobes: got clr=%b inc=%b ld=%b want 000", PC_CLR, PC_INC, PC_LD); end
      tick();
    end
    IR = 16'h3000;
    start_pulse();
  endtask

  task automatic test_reset_mid();
    IR = 16'h6123;
    DR_ZERO = 1'b1;
    for (int t = 0; t <= 4; t++) begin
      @(negedge CLK);
      n_cmp++; if (SC !== 4'(t)) begin n_err++; $display("FAIL isz_pre_sc: got %0d want %0d", SC, t); end
      tick();
    end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++; if (PC_CLR !== 1'b1 || PC_INC !== 1'b0 || SC !== 4'd0 || RUN !== 1'b0) begin n_err++; $display("FAIL midrst_during: got clr=%b inc=%b sc=%0d run=%b want 1 0 0 0", PC_CLR, PC_INC, SC, RUN); end
    tick();
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if (SC !== 4'd0 || RUN !== 1'b0) begin n_err++; $display("FAIL midrst_after: got sc=%0d run=%b want 0 0", SC, RUN); end
    n_cmp++; if (PC_INC !== 1'b0 || PC_CLR !== 1'b0) begin n_err++; $display("FAIL midrst_no_t6: got inc=%b clr=%b want 0 0", PC_INC, PC_CLR); end
    model_ien = 1'b0;
    tick();
    start_pulse();
  endtask

  task automatic test_interrupt();
    IR = 16'hF080;
    FGI = 1'b0;
    FGO = 1'b0;
    for (int t = 0; t <= 3; t++) begin
      @(negedge CLK);
      n_cmp++; if (SC !== 4'(t) || PC_INC !== (t == 1)) begin n_err++; $display("FAIL ion_seq T%0d: got sc=%0d inc=%b want %0d %b", t, SC, PC_INC, t, t == 1); end
      tick();
    end
    model_ien = INTR;
    IR = 16'h4123;
    FGI = 1'b1;
    for (int t = 0; t <= 4; t++) begin
      @(negedge CLK);
      n_cmp++; if (SC !== 4'(t) || PC_LD !== exp_ld(t, IR)) begin n_err++; $display("FAIL irq_bun T%0d: got sc=%0d ld=%b want %0d %b", t, SC, PC_LD, t, exp_ld(t, IR)); end
      n_cmp++; if (IEN !== model_ien) begin n_err++; $display("FAIL irq_ien T%0d: got %b want %b", t, IEN, model_ien); end
      n_cmp++; if (R !== (INTR && t == 4)) begin n_err++; $display("FAIL irq_r T%0d: got %b want %b", t, R, INTR && t == 4); end
      tick();
    end
    FGI = 1'b0;
`ifdef INTERRUPT_EN
    for (int t = 0; t <= 2; t++) begin
      @(negedge CLK);
      n_cmp++; if (SC !== 4'(t) || R !== 1'b1) begin n_err++; $display("FAIL icyc_sc_r T%0d: got sc=%0d r=%b want %0d 1", t, SC, R, t); end
      n_cmp++; if (PC_CLR !== (t == 1) || PC_INC !== (t == 2) || PC_LD !== 1'b0) begin n_err++; $display("FAIL icyc_strobes T%0d: got clr=%b inc=%b ld=%b want %b %b 0", t, PC_CLR, PC_INC, PC_LD, t == 1, t == 2); end
      tick();
    end
    model_ien = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic [15:0] ir;
    for (int k = 0; k < 40; k++) begin
      ir = 16'($urandom);
      if (ir[14:12] == 3'd7) ir[0] = 1'b0;
      if (ir[7] && ir[6]) ir[6] = 1'b0;
      IR = ir;
      DR_ZERO = 1'($urandom);
      AC_SIGN = 1'($urandom);
      AC_ZERO = 1'($urandom);
      E = 1'($urandom);
      for (int t = 0; t <= last_t(ir); t++) begin
        @(negedge CLK);
        n_cmp++; if (SC !== 4'(t) || RUN !== 1'b1) begin n_err++; $display("FAIL rnd_sc ir=%h: got sc=%0d run=%b want %0d 1", ir, SC, RUN, t); end
        n_cmp++; if (PC_INC !== exp_inc(t, ir, DR_ZERO, AC_SIGN, AC_ZERO, E)) begin n_err++; $display("FAIL rnd_inc ir=%h T%0d: got %b want %b", ir, t, PC_INC, exp_inc(t, ir, DR_ZERO, AC_SIGN, AC_ZERO, E)); end
        n_cmp++; if (PC_LD !== exp_ld(t, ir) || PC_CLR !== 1'b0) begin n_err++; $display("FAIL rnd_ld_clr ir=%h T%0d: got ld=%b clr=%b want %b 0", ir, t, PC_LD, PC_CLR, exp_ld(t, ir)); end
        n_cmp++; if (IEN !== model_ien || R !== 1'b0) begin n_err++; $display("FAIL rnd_ien_r ir=%h T%0d: got ien=%b r=%b want %b 0", ir, t, IEN, R, model_ien); end
        tick();
      end
      if (INTR && ir[14:12] == 3'd7 && ir[15]) begin
        if (ir[7]) model_ien = 1'b1;
        else if (ir[6]) model_ien = 1'b0;
      end
    end
    @(negedge CLK);
    n_cmp++; if (SC !== 4'd0 || RUN !== 1'b1) begin n_err++; $display("FAIL rnd_end: got sc=%0d run=%b want 0 1", SC, RUN); end
  endtask

  initial begin
    RST = 1'b1; START = 1'b1; IR = '0;
    DR_ZERO = 1'b0; AC_SIGN = 1'b0; AC_ZERO = 1'b0; E = 1'b1; FGI = 1'b0; FGO = 1'b0;
    test_reset();
    test_fetch();
    test_memref();
    test_regref_halt();
    test_reset_mid();
    test_interrupt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: port CLK, rising-edge clock, and port RST, synchronous active-high reset sampled on CLK rising edge.
REQ-002 CLK  input  1  system clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 START  input  1  level/pulse; begins instruction cycles when idle.
REQ-005 IR  input  16  instruction register contents; valid from T2 onward.
REQ-006 DR_ZERO  input  1  DR==0 flag, used by ISZ.
REQ-007 AC_SIGN  input  1  AC[15].
REQ-008 AC_ZERO  input  1  AC==0 flag.
REQ-009 E  input  1  carry flip-flop value.
REQ-010 FGI, FGO  input  1 each  I/O flags; ignored unless INTERRUPT_EN.
REQ-011 SC  output  4  sequence counter, Tn = value n.
REQ-012 PC_CLR, PC_INC, PC_LD  output  1 each  PC control strobes; PC_LD loads PC from AR; at most one high per cycle.
REQ-013 RUN  output  1  high while instruction cycles execute.
REQ-014 IEN, R  output  1 each  interrupt enable and interrupt-cycle flip-flops.

Function
REQ-015 SC SHALL increment by 1 per CLK while RUN=1, and return to 0 at the end step of each instruction, with no wrap past 15.
REQ-016 Strobes SHALL be combinational from SC, IR, flags and R; D=IR[14:12], I=IR[15].
REQ-017 T1 with R=0: PC_INC=1 (fetch).
REQ-018 D7, T3: register-reference (I=0) or I/O (I=1) execute, then SC<-0.
REQ-019 D7, I=0, T3: PC_INC=1 if (IR[4]&!AC_SIGN)|(IR[3]&AC_SIGN)|(IR[2]&AC_ZERO)|(IR[1]&!E).
REQ-020 D7, I=0, T3, IR[0]: HLT; RUN<-0, SC<-0.
REQ-021 Memory-reference end steps: AND/ADD/LDA (D0-D2) T5; STA (D3) T4; BUN (D4) T4; BSA (D5) T5; ISZ (D6) T6.
REQ-022 BUN T4: PC_LD=1.
REQ-023 BSA T5: PC_LD=1.
REQ-024 ISZ T6: PC_INC=1 if DR_ZERO=1.
REQ-025 T3 indirect step SHALL not affect PC.
REQ-026 START when RUN=0: RUN<-1 and SC<-0 on the next edge.
REQ-027 START when RUN=1 SHALL be ignored.
REQ-028 RUN=0: SC holds 0 and all strobes are 0.
REQ-029 HLT and START in the same cycle: HLT wins, RUN<-0.

Reset
REQ-030 While RST=1: SC=0, RUN=0, IEN=0, R=0, PC_CLR=1, PC_INC=0, PC_LD=0.
REQ-031 RST SHALL override START and any in-progress instruction, including mid-step BSA/ISZ.

Configuration
REQ-032 Macro INTERRUPT_EN SHALL compile in interrupt support.
REQ-033 With INTERRUPT_EN: when SC not in {0,1,2}, IEN=1 and (FGI|FGO)=1, R<-1 on the next edge.
REQ-034 With INTERRUPT_EN, R=1 interrupt cycle: T0 no PC strobe; T1 PC_CLR=1; T2 PC_INC=1, IEN<-0, R<-0, SC<-0.
REQ-035 With INTERRUPT_EN, D7, I=1, T3: IR[7] (ION) sets IEN<-1; IR[6] (IOF) sets IEN<-0.
REQ-036 Without INTERRUPT_EN: IEN and R are constant 0, FGI/FGO are unused, ION/IOF have no effect, and all else is identical.

Verification
REQ-037 RST=1 two cycles, then START pulse -> PC_CLR=1 during reset; SC counts 0,1,2 and PC_INC=1 only at T1.
REQ-038 IR=16'h4123 (BUN) -> PC_LD=1 at T4, SC=0 next cycle; IR=16'h5123 (BSA) -> PC_LD=1 at T5.
REQ-039 IR=16'h6123, DR_ZERO=1 -> PC_INC=1 at T6; repeat with DR_ZERO=0 -> no PC_INC at T6; both end with SC=0.
REQ-040 IR=16'h7004, AC_ZERO=1 -> PC_INC at T3; IR=16'h7001 -> RUN=0, SC=0; START in the same cycle stays ignored.
REQ-041 RST asserted at ISZ T5 -> next cycle SC=0, RUN=0, and no PC_INC at the would-be T6.
REQ-042 INTERRUPT_EN, IR=16'hF080 then FGI=1 during T3+ -> R=1, then PC_CLR at T1 and PC_INC at T2 of the interrupt cycle, then IEN=0 and R=0.
